// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the hazard control unit and the 3-stage F/D/E-W pipeline.
// The datapath side uses the master modport and the hazard unit uses the slave modport.
interface hazard_control_unit_if;
  logic [2:0] rs1_D;
  logic [2:0] rs2_D;
  logic       use_rs1_D;
  logic       use_rs2_D;
  logic [2:0] rs1_E;
  logic [2:0] rs2_E;
  logic [2:0] rd_E;
  logic       mem_read_E;
  logic [1:0] write_mode_E;
  logic [2:0] rd_W;
  logic [1:0] write_mode_W;
  logic       branch_taken_E;
  logic       io_op_E;
  logic       io_ready;
  logic       stall_F;
  logic       flush_F;
  logic       stall_D;
  logic       flush_D;
  logic       stall_E;
  logic       flush_E;
  logic [1:0] fwd_a_E;
  logic [1:0] fwd_b_E;
  logic       io_timeout;

  modport master (
    output rs1_D, rs2_D, use_rs1_D, use_rs2_D, rs1_E, rs2_E, rd_E,
           mem_read_E, write_mode_E, rd_W, write_mode_W,
           branch_taken_E, io_op_E, io_ready,
    input  stall_F, flush_F, stall_D, flush_D, stall_E, flush_E,
           fwd_a_E, fwd_b_E, io_timeout
  );

  modport slave (
    input  rs1_D, rs2_D, use_rs1_D, use_rs2_D, rs1_E, rs2_E, rd_E,
           mem_read_E, write_mode_E, rd_W, write_mode_W,
           branch_taken_E, io_op_E, io_ready,
    output stall_F, flush_F, stall_D, flush_D, stall_E, flush_E,
           fwd_a_E, fwd_b_E, io_timeout
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall/flush and W->E forwarding control for the 3-stage F/D/E-W pipeline.
// Handles multi-cycle load-use bubbles, taken-branch flushes and I/O wait with timeout.
module hazard_control_unit #(
  parameter int MEM_LAT    = 1,
  parameter int IO_TIMEOUT = 15
) (
  input logic                  clk,
  input logic                  reset,
  hazard_control_unit_if.slave hz
);

  localparam int LD_W = $clog2(MEM_LAT + 1);
  localparam int IO_W = $clog2(IO_TIMEOUT + 1);
  localparam logic [LD_W-1:0] LD_LAST = LD_W'(MEM_LAT - 1);
  localparam logic [IO_W-1:0] IO_MAX  = IO_W'(IO_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    IO_WAIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [LD_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [IO_W-1:0] io_cnt_q, io_cnt_d;

  logic       load_use;
  logic       stall_f, flush_f, stall_d, flush_d, flush_e, io_to;
  logic [2:0] rd_w_next;
  logic [1:0] fwd_a, fwd_b;

  assign load_use = hz.mem_read_E && (hz.write_mode_E != 2'b00) &&
                    ((hz.use_rs1_D && (hz.rd_E == hz.rs1_D)) ||
                     (hz.use_rs2_D && (hz.rd_E == hz.rs2_D)));

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    io_cnt_d = io_cnt_q;
    stall_f  = 1'b0;
    flush_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    io_to    = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.io_op_E && !hz.io_ready) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          flush_e  = 1'b1;
          io_cnt_d = IO_W'(1);
          // A one-cycle budget is exhausted by this first stall, so time out here.
          if (IO_TIMEOUT == 1) begin
            io_to    = 1'b1;
            io_cnt_d = '0;
          end else begin
            state_d = IO_WAIT;
          end
        end else if (hz.branch_taken_E) begin
          flush_f = 1'b1;
          flush_d = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          flush_d = 1'b1;
          if (MEM_LAT > 1) begin
            ld_cnt_d = LD_W'(1);
            state_d  = LD_STALL;
          end
        end
      end
      LD_STALL: begin
        if (hz.branch_taken_E) begin
          flush_f  = 1'b1;
          flush_d  = 1'b1;
          ld_cnt_d = '0;
          state_d  = RUN;
        end else begin
          stall_f  = 1'b1;
          flush_d  = 1'b1;
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LD_LAST) begin
            ld_cnt_d = '0;
            state_d  = RUN;
          end
        end
      end
      IO_WAIT: begin
        if (hz.io_ready) begin
          io_cnt_d = '0;
          state_d  = RUN;
        end else if (io_cnt_q < IO_MAX) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          flush_e  = 1'b1;
          io_cnt_d = io_cnt_q + 1'b1;
        end else begin
          io_to    = 1'b1;
          io_cnt_d = '0;
          state_d  = RUN;
        end
      end
      default: begin
        state_d  = RUN;
        ld_cnt_d = '0;
        io_cnt_d = '0;
      end
    endcase
  end

  // Mode 10 writes a register pair, so rd_W+1 (wrapping 7->0) also carries fresh data.
  assign rd_w_next = hz.rd_W + 3'd1;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if ((hz.write_mode_W != 2'b00) && (hz.rd_W == hz.rs1_E)) begin
      fwd_a = 2'b01;
    end else if ((hz.write_mode_W == 2'b10) && (rd_w_next == hz.rs1_E)) begin
      fwd_a = 2'b10;
    end
    if ((hz.write_mode_W != 2'b00) && (hz.rd_W == hz.rs2_E)) begin
      fwd_b = 2'b01;
    end else if ((hz.write_mode_W == 2'b10) && (rd_w_next == hz.rs2_E)) begin
      fwd_b = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      ld_cnt_q <= '0;
      io_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      io_cnt_q <= io_cnt_d;
    end
  end

  // Every output is forced low while reset is held, independent of the inputs.
  assign hz.stall_F    = stall_f & ~reset;
  assign hz.flush_F    = flush_f & ~reset;
  assign hz.stall_D    = stall_d & ~reset;
  assign hz.flush_D    = flush_d & ~reset;
  assign hz.stall_E    = 1'b0;
  assign hz.flush_E    = flush_e & ~reset;
  assign hz.fwd_a_E    = reset ? 2'b00 : fwd_a;
  assign hz.fwd_b_E    = reset ? 2'b00 : fwd_b;
  assign hz.io_timeout = io_to & ~reset;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: a MEM_LAT=1 and a MEM_LAT=3 instance share stimulus.
// Expected output vectors come from a reference model and are queued when stimulus is driven.
module tb_hazard_control_unit;

  localparam int IOT = 15;

  typedef struct packed {
    logic [2:0] rs1_D;
    logic [2:0] rs2_D;
    logic       use_rs1_D;
    logic       use_rs2_D;
    logic [2:0] rs1_E;
    logic [2:0] rs2_E;
    logic [2:0] rd_E;
    logic       mem_read_E;
    logic [1:0] write_mode_E;
    logic [2:0] rd_W;
    logic [1:0] write_mode_W;
    logic       branch_taken_E;
    logic       io_op_E;
    logic       io_ready;
  } stim_t;

  logic clk;
  logic reset;

  hazard_control_unit_if hz0 ();
  hazard_control_unit_if hz1 ();

  hazard_control_unit #(.MEM_LAT(1), .IO_TIMEOUT(IOT)) u_dut_ml1 (
    .clk   (clk),
    .reset (reset),
    .hz    (hz0.slave)
  );

  hazard_control_unit #(.MEM_LAT(3), .IO_TIMEOUT(IOT)) u_dut_ml3 (
    .clk   (clk),
    .reset (reset),
    .hz    (hz1.slave)
  );

  assign hz1.rs1_D          = hz0.rs1_D;
  assign hz1.rs2_D          = hz0.rs2_D;
  assign hz1.use_rs1_D      = hz0.use_rs1_D;
  assign hz1.use_rs2_D      = hz0.use_rs2_D;
  assign hz1.rs1_E          = hz0.rs1_E;
  assign hz1.rs2_E          = hz0.rs2_E;
  assign hz1.rd_E           = hz0.rd_E;
  assign hz1.mem_read_E     = hz0.mem_read_E;
  assign hz1.write_mode_E   = hz0.write_mode_E;
  assign hz1.rd_W           = hz0.rd_W;
  assign hz1.write_mode_W   = hz0.write_mode_W;
  assign hz1.branch_taken_E = hz0.branch_taken_E;
  assign hz1.io_op_E        = hz0.io_op_E;
  assign hz1.io_ready       = hz0.io_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];

  // Reference model state: bubbles still owed, and I/O wait progress.
  int m_ld_left[2];
  bit m_io_wait[2];
  int m_io_stalls[2];

  task automatic checkOutput(input string tag, input logic [10:0] observed,
                             input logic [10:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b (sF fF sD fD sE fE fa fb to)",
               tag, observed, expected);
    end
  endtask

  function automatic logic [1:0] fwdSel(input logic [2:0] rd_w, input logic [1:0] wm_w,
                                        input logic [2:0] rs);
    int pair;
    pair = (int'(rd_w) + 1) % 8;
    if (wm_w != 2'b00 && rd_w == rs) return 2'b01;
    if (wm_w == 2'b10 && pair == int'(rs)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [10:0] modelStep(input int i, input int mem_lat, input stim_t v);
    logic sf, ff, sd, fd, fe, to;
    logic [1:0] fa, fb;
    bit lu;
    sf = 0; ff = 0; sd = 0; fd = 0; fe = 0; to = 0;
    lu = v.mem_read_E && (v.write_mode_E != 2'b00) &&
         ((v.use_rs1_D && v.rd_E == v.rs1_D) || (v.use_rs2_D && v.rd_E == v.rs2_D));
    fa = fwdSel(v.rd_W, v.write_mode_W, v.rs1_E);
    fb = fwdSel(v.rd_W, v.write_mode_W, v.rs2_E);
    if (m_io_wait[i]) begin
      if (v.io_ready) begin
        m_io_wait[i] = 0;
      end else if (m_io_stalls[i] < IOT) begin
        sf = 1; sd = 1; fe = 1;
        m_io_stalls[i]++;
      end else begin
        to = 1;
        m_io_wait[i] = 0;
      end
    end else if (m_ld_left[i] > 0) begin
      if (v.branch_taken_E) begin
        ff = 1; fd = 1;
        m_ld_left[i] = 0;
      end else begin
        sf = 1; fd = 1;
        m_ld_left[i]--;
      end
    end else if (v.io_op_E && !v.io_ready) begin
      sf = 1; sd = 1; fe = 1;
      m_io_stalls[i] = 1;
      m_io_wait[i] = 1;
    end else if (v.branch_taken_E) begin
      ff = 1; fd = 1;
    end else if (lu) begin
      sf = 1; fd = 1;
      m_ld_left[i] = mem_lat - 1;
    end
    return {sf, ff, sd, fd, 1'b0, fe, fa, fb, to};
  endfunction

  // Drives one cycle of stimulus, queues both expectations, then checks at the falling edge.
  task automatic applyStimulus(input string tag, input stim_t v, input logic rst_v);
    logic [10:0] e0, e1;
    reset                = rst_v;
    hz0.rs1_D            = v.rs1_D;
    hz0.rs2_D            = v.rs2_D;
    hz0.use_rs1_D        = v.use_rs1_D;
    hz0.use_rs2_D        = v.use_rs2_D;
    hz0.rs1_E            = v.rs1_E;
    hz0.rs2_E            = v.rs2_E;
    hz0.rd_E             = v.rd_E;
    hz0.mem_read_E       = v.mem_read_E;
    hz0.write_mode_E     = v.write_mode_E;
    hz0.rd_W             = v.rd_W;
    hz0.write_mode_W     = v.write_mode_W;
    hz0.branch_taken_E   = v.branch_taken_E;
    hz0.io_op_E          = v.io_op_E;
    hz0.io_ready         = v.io_ready;
    if (rst_v) begin
      for (int i = 0; i < 2; i++) begin
        m_ld_left[i] = 0; m_io_wait[i] = 0; m_io_stalls[i] = 0;
      end
      e0 = '0;
      e1 = '0;
    end else begin
      e0 = modelStep(0, 1, v);
      e1 = modelStep(1, 3, v);
    end
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
    @(negedge clk);
    if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: scoreboard empty, got none required one entry", tag);
    end else begin
      checkOutput({tag, "/ml1"},
                  {hz0.stall_F, hz0.flush_F, hz0.stall_D, hz0.flush_D, hz0.stall_E,
                   hz0.flush_E, hz0.fwd_a_E, hz0.fwd_b_E, hz0.io_timeout},
                  exp_q0.pop_front());
      checkOutput({tag, "/ml3"},
                  {hz1.stall_F, hz1.flush_F, hz1.stall_D, hz1.flush_D, hz1.stall_E,
                   hz1.flush_E, hz1.fwd_a_E, hz1.fwd_b_E, hz1.io_timeout},
                  exp_q1.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  stim_t idle, ld, v;

  initial begin
    idle = '0;
    reset = 1'b1;
    hz0.rs1_D = '0; hz0.rs2_D = '0; hz0.use_rs1_D = 0; hz0.use_rs2_D = 0;
    hz0.rs1_E = '0; hz0.rs2_E = '0; hz0.rd_E = '0; hz0.mem_read_E = 0;
    hz0.write_mode_E = '0; hz0.rd_W = '0; hz0.write_mode_W = '0;
    hz0.branch_taken_E = 0; hz0.io_op_E = 0; hz0.io_ready = 0;
    @(posedge clk);
    #1;

    applyStimulus("reset", idle, 1'b1);
    applyStimulus("reset", idle, 1'b1);
    applyStimulus("idle", idle, 1'b0);

    // Load r3 in E, D reads r3 via rs1: 1 bubble for ml1, 3 for ml3.
    ld = idle;
    ld.mem_read_E = 1; ld.write_mode_E = 2'b01; ld.rd_E = 3'd3;
    ld.use_rs1_D = 1; ld.rs1_D = 3'd3;
    applyStimulus("ld_use", ld, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus("ld_tail", idle, 1'b0);

    v = ld; v.use_rs1_D = 0;
    applyStimulus("ld_nouse", v, 1'b0);
    v = ld; v.write_mode_E = 2'b00;
    applyStimulus("ld_nowrite", v, 1'b0);
    v = ld; v.use_rs1_D = 0; v.use_rs2_D = 1; v.rs2_D = 3'd3; v.rs1_D = 3'd5;
    applyStimulus("ld_rs2", v, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus("ld_rs2_tail", idle, 1'b0);

    // Branch beats load-use; then a branch arriving mid LD_STALL ends the stall.
    v = ld; v.branch_taken_E = 1;
    applyStimulus("br_ld", v, 1'b0);
    applyStimulus("br_after", idle, 1'b0);
    applyStimulus("ld_then_br", ld, 1'b0);
    v = idle; v.branch_taken_E = 1;
    applyStimulus("br_in_stall", v, 1'b0);
    applyStimulus("br_in_stall_after", idle, 1'b0);

    // Forwarding including the 7->0 register pair wrap.
    v = idle; v.rd_W = 3'd7; v.write_mode_W = 2'b10; v.rs1_E = 3'd0; v.rs2_E = 3'd7;
    applyStimulus("fwd_pair", v, 1'b0);
    v.write_mode_W = 2'b00;
    applyStimulus("fwd_none", v, 1'b0);
    v.write_mode_W = 2'b11;
    applyStimulus("fwd_wm3", v, 1'b0);
    v = idle; v.rd_W = 3'd0; v.write_mode_W = 2'b01; v.rs1_E = 3'd0; v.rs2_E = 3'd1;
    applyStimulus("fwd_r0", v, 1'b0);

    // I/O not ready for 4 cycles, then ready.
    v = idle; v.io_op_E = 1; v.io_ready = 0;
    for (int k = 0; k < 4; k++) applyStimulus("io_wait", v, 1'b0);
    v.io_ready = 1;
    applyStimulus("io_ready", v, 1'b0);
    applyStimulus("io_after", idle, 1'b0);

    // I/O never ready: 15 stalls then a timeout pulse; a branch mid-wait is ignored.
    v = idle; v.io_op_E = 1; v.io_ready = 0;
    for (int k = 0; k < IOT + 1; k++) begin
      v.branch_taken_E = (k == 5);
      applyStimulus("io_timeout", v, 1'b0);
    end
    applyStimulus("io_to_after", idle, 1'b0);

    // Reset during the third IO_WAIT cycle, then release with no I/O pending.
    v = idle; v.io_op_E = 1; v.io_ready = 0;
    for (int k = 0; k < 3; k++) applyStimulus("io_pre_rst", v, 1'b0);
    applyStimulus("io_rst", v, 1'b1);
    applyStimulus("post_rst", idle, 1'b0);
    applyStimulus("post_rst", idle, 1'b0);

    // Mixed random traffic against the model.
    for (int k = 0; k < 60; k++) begin
      v.rs1_D          = 3'($urandom_range(0, 7));
      v.rs2_D          = 3'($urandom_range(0, 7));
      v.use_rs1_D      = 1'($urandom_range(0, 1));
      v.use_rs2_D      = 1'($urandom_range(0, 1));
      v.rs1_E          = 3'($urandom_range(0, 7));
      v.rs2_E          = 3'($urandom_range(0, 7));
      v.rd_E           = 3'($urandom_range(0, 7));
      v.mem_read_E     = 1'($urandom_range(0, 1));
      v.write_mode_E   = 2'($urandom_range(0, 3));
      v.rd_W           = 3'($urandom_range(0, 7));
      v.write_mode_W   = 2'($urandom_range(0, 3));
      v.branch_taken_E = ($urandom_range(0, 4) == 0);
      v.io_op_E        = ($urandom_range(0, 5) == 0);
      v.io_ready       = ($urandom_range(0, 2) == 0);
      applyStimulus("random", v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
